// File: rtl/radio_audio_averager.sv
// Averages 2^k signed audio samples and emits the mean over a stb/ack stream.
// Define AVERAGER_ROUNDING_EN for round-half-up instead of floor.
module radio_audio_averager #(
   parameter int SAMPLE_W   = 16,
   parameter int MAX_LOG2   = 8,
   parameter int RESET_LOG2 = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [SAMPLE_W-1:0] sample_in,
   input  logic                       sample_in_valid,
   input  logic [31:0]                input_average_samples,
   input  logic                       input_average_samples_stb,
   output logic                       input_average_samples_ack,
   output logic [31:0]                output_audio,
   output logic                       output_audio_stb,
   input  logic                       output_audio_ack,
   output logic                       overflow
);

`ifdef AVERAGER_ROUNDING_EN
   localparam int GUARD = 1;
`else
   localparam int GUARD = 0;
`endif
   localparam int AW = SAMPLE_W + MAX_LOG2 + GUARD;
   localparam int KW = $clog2(MAX_LOG2 + 1);
   localparam int CW = MAX_LOG2 + 1;

   typedef enum logic {CFG_WAIT, CFG_APPLY} cfg_state_e;

   cfg_state_e            state_q, state_d;
   logic                  ack_q, ack_d;
   logic [KW-1:0]         k_q, k_d;
   logic signed [AW-1:0]  acc_q, acc_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [31:0]           audio_q, audio_d;
   logic                  stb_q, stb_d;
   logic                  ovf_q, ovf_d;

   logic signed [AW-1:0]  sample_ext, sum, res;
   logic [CW-1:0]         win_last;
   logic                  done;

   function automatic logic signed [AW-1:0] avg_shift(input logic signed [AW-1:0] s,
                                                      input logic [KW-1:0] k);
`ifdef AVERAGER_ROUNDING_EN
      logic signed [AW-1:0] bias;
      bias = (k == '0) ? '0 : ({{(AW-1){1'b0}}, 1'b1} << (k - KW'(1)));
      return (s + bias) >>> k;
`else
      return s >>> k;
`endif
   endfunction

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      audio_d = audio_q;
      stb_d   = stb_q;
      ovf_d   = 1'b0;

      sample_ext = {{(AW-SAMPLE_W){sample_in[SAMPLE_W-1]}}, sample_in};
      sum        = acc_q + sample_ext;
      win_last   = (CW'(1) << k_q) - CW'(1);
      done       = sample_in_valid && (state_q == CFG_WAIT) && (cnt_q == win_last);
      res        = avg_shift(sum, k_q);

      // The completing sample is always evaluated with the k that was in force for its window.
      if (state_q == CFG_WAIT) begin
         if (sample_in_valid) begin
            if (done) begin
               acc_d = '0;
               cnt_d = '0;
            end else begin
               acc_d = sum;
               cnt_d = cnt_q + CW'(1);
            end
         end
         if (input_average_samples_stb && ack_q) begin
            k_d     = (input_average_samples > 32'(MAX_LOG2)) ? KW'(MAX_LOG2)
                                                              : input_average_samples[KW-1:0];
            state_d = CFG_APPLY;
         end
      end else begin
         acc_d   = '0;
         cnt_d   = '0;
         state_d = CFG_WAIT;
      end

      if (stb_q && !output_audio_ack) begin
         ovf_d = done;
      end else if (done) begin
         audio_d = 32'(res);
         stb_d   = 1'b1;
      end else begin
         stb_d   = 1'b0;
      end

      ack_d = (state_d == CFG_WAIT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= CFG_WAIT;
         ack_q   <= 1'b0;
         k_q     <= KW'(RESET_LOG2);
         acc_q   <= '0;
         cnt_q   <= '0;
         audio_q <= '0;
         stb_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         audio_q <= audio_d;
         stb_q   <= stb_d;
         ovf_q   <= ovf_d;
      end
   end

   assign input_average_samples_ack = ack_q;
   assign output_audio              = audio_q;
   assign output_audio_stb          = stb_q;
   assign overflow                  = ovf_q;

endmodule

// File: doc/radio_audio_averager.md
Name: radio_audio_averager

Overview:
- Upstream neighbour of the radio user design: produces the 32-bit input_radio_audio stream that the design consumes.
- Consumes the design's output_radio_average_samples stream as its averaging-length control.
- Raw demodulated audio arrives at the ADC/demodulator rate. The block sums 2^k samples and emits their arithmetic mean over a stb/ack stream, decimating by 2^k.

Parameters:
SAMPLE_W, 16, width of signed raw audio sample
MAX_LOG2, 8, largest averaging exponent k accepted (max 256 samples)
RESET_LOG2, 0, exponent in force after reset (k=0 means pass-through, decimation 1)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous active-low reset (0 = reset)
sample_in  in  SAMPLE_W  signed raw audio sample
sample_in_valid  in  1  one-cycle strobe per sample; no backpressure possible
input_average_samples  in  32  requested exponent k (unsigned)
input_average_samples_stb  in  1  control word valid
input_average_samples_ack  out  1  control word accepted
output_audio  out  32  sign-extended averaged sample
output_audio_stb  out  1  output word valid
output_audio_ack  in  1  consumer accepts word
overflow  out  1  one-cycle pulse when a result is dropped

Behaviour:
- Reset (rst=0, async) clears state and outputs:
  - k=RESET_LOG2; accumulator=0; count=0; control FSM in CFG_WAIT.
  - output_audio=0; output_audio_stb=0; input_average_samples_ack=0; overflow=0.
  - Reset release is synchronous to clk; first ack is seen one cycle after release.
- A transfer occurs on any cycle where stb&&ack is high. Data is sampled on that edge.
- Control FSM:
  - CFG_WAIT: ack=1. On stb&&ack, capture k=min(value, MAX_LOG2) and go to CFG_APPLY.
  - CFG_APPLY: ack=0 for one cycle. Accumulator and count clear. Any sample_in_valid in this cycle is discarded. Returns to CFG_WAIT.
  - A pending output word is unaffected by reconfiguration.
- Accumulation:
  - Accumulator width SAMPLE_W+MAX_LOG2, signed; it cannot overflow.
  - On sample_in_valid: acc+=sample, count+=1.
  - When the incoming sample is the 2^k-th, the result is acc_including_this_sample >>> k (arithmetic shift), computed that cycle. Accumulator and count clear on the same edge, and the next sample starts a fresh window.
- Output register:
  - A result is loaded into output_audio, sign-extended to 32 bits, with stb=1 on the edge after the completing sample. Latency is 1 cycle.
  - stb holds, and data stays stable, until stb&&ack.
  - A transfer plus a new result in the same cycle: the register reloads and stb stays 1, giving back-to-back words with no bubble.
  - A transfer with no new result: stb=0 next cycle.
  - A new result while stb=1 and ack=0: the new result is dropped, the held word is kept, and overflow pulses for 1 cycle.
- k=0: every valid sample is forwarded unchanged, at 1-cycle latency.
- A config transfer and a completing sample in the same cycle: the completing result is still emitted, then CFG_APPLY clears the accumulator.
- Mid-operation reset: the partial window and any pending output are discarded with no output transfer. After release, k=RESET_LOG2.

Optional Feature:
- AVERAGER_ROUNDING_EN defined: for k>0, the result is (acc+2^(k-1))>>>k (round half up). The accumulator carries one guard bit to absorb the addition.
- Not defined: plain truncation, i.e. floor via arithmetic shift.
- k=0 output is identical in both builds.

Test Plan:
- Reset then k=0; samples 5, -3, 32767 on consecutive cycles, ack tied 1 -> output_audio 5, 0xFFFFFFFD, 32767 on consecutive cycles, each one cycle after its input.
- Config 2 (ack seen, one APPLY cycle); samples 10, 11, 12, 14 -> single word 11. Samples -1, -1, -1, -2 -> 0xFFFFFFFE without rounding; 0xFFFFFFFF with AVERAGER_ROUNDING_EN (-5/4 rounds half up to -1).
- Config 20 -> k clamps to 8. 256 samples of 100 -> one word 100; 255 samples -> no word.
- k=0, ack held 0, three samples -> first word held stable, overflow pulses twice. Then ack=1 -> first word transferred, stb drops.
- Config arrives in the same cycle as the 4th sample at k=2 -> averaged word still emitted. The next window uses the new k and excludes any sample present during CFG_APPLY.
- Assert rst mid-window (2 of 4 samples) with stb pending -> stb=0 and output_audio=0 immediately, without waiting for clk; k=RESET_LOG2 after release.
